hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
//
// PURPOSE
//  Registered, parametrised seven-segment driver for the DE2 HEX bank.
//  It captures a data word on a load strobe and decodes one hex nibble per digit.
//  It supports global blanking and a hardware blink for halt/attention indication.
//  It sits between the system interface (e.g. syif.load, syif.halt) and the board HEX pins.
//  Top-level FPGA wrappers use it instead of per-digit combinational decoders.
//
// PARAMETERS
//  NDIGITS    8         number of digits driven; data width is 4*NDIGITS
//  BLINK_DIV  25000000  clock cycles per blink half-period; legal values are >= 2
//
// PORTS
//  CLK      in   1          system clock, rising edge
//  nRST     in   1          asynchronous active-low reset
//  data_i   in   4*NDIGITS  value to display; digit k shows data_i[4k+3:4k]
//  load_i   in   1          capture data_i on the rising edge when high
//  en_i     in   1          display enable; 0 blanks all digits
//  blink_i  in   1          1 makes the display blink at the BLINK_DIV rate
//  seg_o    out  7*NDIGITS  segments, active-low gfedcba; digit k is at [7k+6:7k]
//  phase_o  out  1          current blink phase; 1 = visible
//
// BEHAVIOUR
//  - State registers
//    - val_q: 4*NDIGITS bits, the held value.
//    - cnt_q: $clog2(BLINK_DIV) bits, the blink counter.
//    - phase_q: the blink phase.
//    - seg_q: drives seg_o.
//  - Reset (nRST=0, asynchronous):
//    - val_q=0, cnt_q=0, phase_q=1.
//    - seg_o = all ones (every digit blank).
//    - phase_o=1.
//  - Capture: val_q <= data_i on any edge with load_i=1; otherwise val_q holds.
//    - Capture still occurs while en_i=0.
//    - load_i held high makes val_q track data_i every cycle.
//  - Blink counter:
//    - blink_i=0: cnt_q <= 0 and phase_q <= 1.
//    - blink_i=1: cnt_q increments each cycle. At cnt_q==BLINK_DIV-1 it wraps to 0 and phase_q toggles.
//    - A full blink period is therefore 2*BLINK_DIV cycles.
//    - Deasserting blink_i mid-period restores visibility on the next edge.
//  - Output register, updated every edge:
//    - seg_q digit k = en_i && (phase_q || !blink_i) ? dec(val_q[4k+3:4k]) : 7'h7F.
//  - Latency:
//    - load_i sampled on edge n gives the new digits on seg_o after edge n+1.
//    - en_i and blink_i changes reach seg_o after one edge.
//  - Decode, dec() in hex, 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 27 21 06 0E.
//  - Simultaneous events:
//    - A load on the same edge as a phase toggle applies both.
//    - During a visible phase, the output after the next edge shows the new value.
//  - Reset mid-blink: phase returns to visible. The display blanks until the first post-reset edge, then shows 0s.
//  - phase_o = phase_q. It is a registered output for an LED mirror.
//
// CONFIGURATION
//  HEXDISP_LZB_EN: leading-zero blanking.
//  - Defined:
//    - Digits above the most-significant nonzero nibble of val_q output 7'h7F.
//    - Digit 0 is always shown, so val_q==0 displays a single "0".
//    - Blanking is computed from val_q in the same cycle and adds no latency.
//  - Undefined: all NDIGITS digits are always decoded, leading zeros included.
//
// TESTING (NDIGITS=8, BLINK_DIV=4)
//  1. Reset, then en_i=1 and no load:
//     - seg_o=all 1s during reset.
//     - After 1 edge, every digit is 7'h40.
//  2. data_i=32'h0123ABCD with one load_i pulse, then change data_i to 0:
//     - Digits 7..0 are 40 79 24 30 08 03 27 21.
//     - The digits stay held after data_i changes.
//  3. blink_i=1 for 20 cycles:
//     - phase_o toggles every 4 cycles.
//     - seg_o alternates between the value and all 1s.
//     - Dropping blink_i gives visible digits after 1 edge.
//  4. en_i=0 while loading 32'hFFFFFFFF:
//     - seg_o stays all 1s.
//     - Setting en_i=1 shows all digits 7'h0E after 1 edge.
//  5. HEXDISP_LZB_EN defined, load 32'h000000A0:
//     - Digits 1,0 = 08 40; digits 7..2 = 7F.
//     - Loading 0 shows digit0=40, all others 7F.
//  6. Assert nRST while phase_q=0 with val_q=32'h12345678:
//     - seg_o goes to all 1s immediately (asynchronous reset) and phase_o=1.
//     - Digits show 40 after the first edge.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered seven-segment driver with capture, blanking and blink
// Optional leading-zero blanking is enabled by defining HEXDISP_LZB_EN.
module hex_display_ctrl #(
    parameter int NDIGITS   = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [4*NDIGITS-1:0]   data_i,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic                   blink_i,
    output logic [7*NDIGITS-1:0]   seg_o,
    output logic                   phase_o
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [4*NDIGITS-1:0] val_q;
    logic [CW-1:0]        cnt_q;
    logic                 phase_q;
    logic [7*NDIGITS-1:0] seg_q;
    logic [7*NDIGITS-1:0] seg_d;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h27;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        logic show;
        logic nz_above;
        seg_d    = '1;
        show     = en_i && (phase_q || !blink_i);
        nz_above = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (show) begin
                seg_d[7*k +: 7] = dec(val_q[4*k +: 4]);
            end
        end
`ifdef HEXDISP_LZB_EN
        // Walk down from the top digit; blank until the first nonzero nibble, never digit 0.
        for (int k = NDIGITS - 1; k > 0; k--) begin
            nz_above = nz_above | (|val_q[4*k +: 4]);
            if (!nz_above) begin
                seg_d[7*k +: 7] = 7'h7F;
            end
        end
`else
        nz_above = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            val_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            seg_q   <= '1;
        end else begin
            if (load_i) begin
                val_q <= data_i;
            end
            if (!blink_i) begin
                cnt_q   <= '0;
                phase_q <= 1'b1;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            seg_q <= seg_d;
        end
    end

    assign seg_o   = seg_q;
    assign phase_o = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - randomized and directed bench for hex_display_ctrl
module tb_hex_display_ctrl;

    localparam int ND = 8;
    localparam int BD = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [31:0]   data_i = '0;
    logic          load_i = 1'b0;
    logic          en_i = 1'b0;
    logic          blink_i = 1'b0;
    logic [55:0]   seg_o;
    logic          phase_o;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    hex_display_ctrl #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
        .CLK(CLK), .nRST(nRST), .data_i(data_i), .load_i(load_i),
        .en_i(en_i), .blink_i(blink_i), .seg_o(seg_o), .phase_o(phase_o)
    );

    always #5 CLK = ~CLK;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    localparam logic [55:0] ALL_BLANK = {56{1'b1}};

    // Reference state: held value and how many consecutive edges blink has been high.
    logic [31:0] m_val = '0;
    int          m_run = 0;
    logic [55:0] exp_seg = ALL_BLANK;
    logic        exp_phase = 1'b1;

    function automatic logic visible(input int run);
        return ((run / BD) % 2) == 0;
    endfunction

    function automatic logic [55:0] model_seg(input logic [31:0] v, input logic vis,
                                              input logic en, input logic bl);
        logic [55:0] s;
        s = ALL_BLANK;
        for (int k = 0; k < ND; k++) begin
            if (en && (vis || !bl)) s[7*k +: 7] = dec_tab[v[4*k +: 4]];
`ifdef HEXDISP_LZB_EN
            if (k > 0 && (v >> (4*k)) == 32'd0) s[7*k +: 7] = 7'h7F;
`endif
        end
        return s;
    endfunction

    function automatic logic [55:0] lit8(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_val     = '0;
            m_run     = 0;
            exp_seg   = ALL_BLANK;
            exp_phase = 1'b1;
        end else begin
            exp_seg   = model_seg(m_val, visible(m_run), en_i, blink_i);
            if (load_i) m_val = data_i;
            m_run     = blink_i ? m_run + 1 : 0;
            exp_phase = visible(m_run);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("seg_o", {8'h0, seg_o}, {8'h0, exp_seg});
            check("phase_o", {63'h0, phase_o}, {63'h0, exp_phase});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0;
        en_i = 1'b1;
        #13;
        check("reset_seg", {8'h0, seg_o}, {8'h0, ALL_BLANK});
        check("reset_phase", {63'h0, phase_o}, 64'h1);
        tick(1);
        nRST = 1'b1;
        chk_en = 1'b1;
        tick(1);
        check("t1_zeros", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)});

        data_i = 32'h0123ABCD; load_i = 1'b1;
        tick(1);
        load_i = 1'b0; data_i = '0;
        tick(1);
        check("t2_value", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h27, 7'h21)});
        tick(2);
        check("t2_held", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h27, 7'h21)});

        blink_i = 1'b1;
        tick(3);
        check("t3_phase_vis", {63'h0, phase_o}, 64'h1);
        tick(3);
        check("t3_blank", {8'h0, seg_o}, {8'h0, ALL_BLANK});
        check("t3_phase_off", {63'h0, phase_o}, 64'h0);
        tick(4);
        check("t3_phase_back", {63'h0, phase_o}, 64'h1);
        tick(10);
        blink_i = 1'b0;
        tick(1);
        check("t3_restore", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h27, 7'h21)});
        check("t3_restore_ph", {63'h0, phase_o}, 64'h1);

        en_i = 1'b0; data_i = 32'hFFFFFFFF; load_i = 1'b1;
        tick(1);
        load_i = 1'b0;
        tick(2);
        check("t4_disabled", {8'h0, seg_o}, {8'h0, ALL_BLANK});
        en_i = 1'b1;
        tick(1);
        check("t4_all_f", {8'h0, seg_o}, {8'h0, lit8(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E)});

        data_i = 32'h000000A0; load_i = 1'b1;
        tick(1);
        load_i = 1'b0;
        tick(1);
`ifdef HEXDISP_LZB_EN
        check("t5_a0", {8'h0, seg_o}, {8'h0, lit8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40)});
`else
        check("t5_a0", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40)});
`endif
        data_i = 32'h0; load_i = 1'b1;
        tick(1);
        load_i = 1'b0;
        tick(1);
`ifdef HEXDISP_LZB_EN
        check("t5_zero", {8'h0, seg_o}, {8'h0, lit8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)});
`else
        check("t5_zero", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)});
`endif

        data_i = 32'h12345678; load_i = 1'b1;
        tick(1);
        load_i = 1'b0; blink_i = 1'b1;
        tick(5);
        check("t6_phase_low", {63'h0, phase_o}, 64'h0);
        nRST = 1'b0;
        #1;
        check("t6_async_seg", {8'h0, seg_o}, {8'h0, ALL_BLANK});
        check("t6_async_ph", {63'h0, phase_o}, 64'h1);
        blink_i = 1'b0;
        tick(2);
        nRST = 1'b1;
        tick(1);
        check("t6_zeros", {8'h0, seg_o}, {8'h0, lit8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40)});

        for (int i = 0; i < 400; i++) begin
            data_i  = $urandom >> $urandom_range(0, 31);
            load_i  = ($urandom_range(0, 3) == 0);
            en_i    = ($urandom_range(0, 7) != 0);
            blink_i = ($urandom_range(0, 15) != 0);
            tick(1);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
